// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery controller.
// Tracks in-flight branches in a circular checkpoint FIFO. A mispredict runs
// FLUSH (restore pulse) then REDIRECT (fetch redirect pulse) before dispatch
// resumes.

`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module branch_recovery_ctrl #(
    parameter int CP_COUNT = 4,
    parameter int ROB_AW   = $clog2(`ROB_SIZE),
    parameter int CPW      = $clog2(CP_COUNT)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 alloc_req,
    input  logic [ROB_AW-1:0]    alloc_rob_addr,
    output logic                 alloc_grant,
    output logic [CPW-1:0]       alloc_cp_id,
    output logic                 dispatch_stall,
    input  logic                 resolve_valid,
    input  logic [CPW-1:0]       resolve_cp_id,
    input  logic                 resolve_mispredict,
    input  logic [`PC_SIZE-1:0]  resolve_target,
    output logic                 resolve_ready,
    output logic                 restore,
    output logic [ROB_AW-1:0]    restore_tail,
    output logic [CPW-1:0]       restore_cp_id,
    output logic                 redirect_valid,
    output logic [`PC_SIZE-1:0]  redirect_pc,
    output logic [CPW:0]         outstanding
);

    localparam logic [CPW:0]        CP_FULL  = CP_COUNT[CPW:0];
    localparam logic [ROB_AW-1:0]   ROB_LAST = ROB_AW'(`ROB_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CPW-1:0]       head;
    logic [CPW-1:0]       tail;
    logic [CPW-1:0]       head_next;
    logic [CP_COUNT-1:0]  slot_valid;
    logic [CP_COUNT-1:0]  slot_resolved;
    logic [ROB_AW-1:0]    slot_rob   [CP_COUNT];
    logic [`PC_SIZE-1:0]  slot_target[CP_COUNT];

    logic [CPW-1:0]       flush_cp;
    logic [ROB_AW-1:0]    flush_tail;

    logic                 retire;
    logic                 accept;
    logic                 mis_accept;
    logic                 ok_accept;
    logic [CP_COUNT-1:0]  kill;

    // The registered count decides fullness, so a same-cycle retire cannot
    // free a slot for a grant and no combinational loop forms.
    assign alloc_grant    = alloc_req && (state == IDLE) && (outstanding < CP_FULL);
    assign alloc_cp_id    = tail;
    assign dispatch_stall = (outstanding == CP_FULL) || (state != IDLE);
    assign resolve_ready  = (state == IDLE);

    assign retire     = slot_valid[head] && slot_resolved[head];
    assign head_next  = head + CPW'(retire);
    assign accept     = resolve_valid && (state == IDLE) && slot_valid[resolve_cp_id];
    assign mis_accept = accept && resolve_mispredict;
    assign ok_accept  = accept && !resolve_mispredict;

    // Mark the mispredicted slot and everything younger (by age from head) for
    // invalidation; slots outside the live range are already invalid.
    always_comb begin
        kill = '0;
        for (int i = 0; i < CP_COUNT; i++) begin
            kill[i] = (CPW'(i) - head) >= (flush_cp - head);
        end
    end

    // State register for the recovery sequence; reset abandons any recovery.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and the one-cycle restore/redirect pulses.
    always_comb begin
        state_next     = state;
        restore        = 1'b0;
        restore_tail   = '0;
        restore_cp_id  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (mis_accept) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                restore       = 1'b1;
                restore_tail  = flush_tail;
                restore_cp_id = flush_cp;
                state_next    = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = slot_target[flush_cp];
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Checkpoint FIFO: allocate at tail, mark resolutions, retire from head,
    // and on FLUSH drop the mispredicted slot and all younger ones. The
    // retire clear comes last so it wins over any write to the same slot.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head          <= '0;
            tail          <= '0;
            outstanding   <= '0;
            slot_valid    <= '0;
            slot_resolved <= '0;
            flush_cp      <= '0;
            flush_tail    <= '0;
        end else begin
            if (alloc_grant) begin
                slot_valid[tail]    <= 1'b1;
                slot_resolved[tail] <= 1'b0;
                slot_rob[tail]      <= alloc_rob_addr;
                tail                <= tail + CPW'(1);
            end

            if (accept) begin
                slot_target[resolve_cp_id] <= resolve_target;
            end
            if (ok_accept) begin
                slot_resolved[resolve_cp_id] <= 1'b1;
            end
            if (mis_accept) begin
                flush_cp   <= resolve_cp_id;
                flush_tail <= (slot_rob[resolve_cp_id] == ROB_LAST) ?
                              '0 : slot_rob[resolve_cp_id] + ROB_AW'(1);
            end

            if (state == FLUSH) begin
                slot_valid    <= slot_valid & ~kill;
                slot_resolved <= slot_resolved & ~kill;
                tail          <= flush_cp;
                outstanding   <= {1'b0, flush_cp - head_next};
                if (retire) begin
                    slot_valid[head]    <= 1'b0;
                    slot_resolved[head] <= 1'b0;
                end
            end else begin
                outstanding <= outstanding + {{CPW{1'b0}}, alloc_grant}
                                           - {{CPW{1'b0}}, retire};
                if (retire) begin
                    slot_valid[head]    <= 1'b0;
                    slot_resolved[head] <= 1'b0;
                end
            end

            head <= head_next;
        end
    end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed testbench for branch_recovery_ctrl: allocation, retirement,
// mispredict recovery timing, ROB wrap, pointer wrap and reset mid-recovery.

`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module tb_branch_recovery_ctrl;

    localparam int CP_COUNT = 4;
    localparam int ROB_AW   = $clog2(`ROB_SIZE);
    localparam int CPW      = $clog2(CP_COUNT);

    logic                 clk;
    logic                 n_rst;
    logic                 alloc_req;
    logic [ROB_AW-1:0]    alloc_rob_addr;
    logic                 alloc_grant;
    logic [CPW-1:0]       alloc_cp_id;
    logic                 dispatch_stall;
    logic                 resolve_valid;
    logic [CPW-1:0]       resolve_cp_id;
    logic                 resolve_mispredict;
    logic [`PC_SIZE-1:0]  resolve_target;
    logic                 resolve_ready;
    logic                 restore;
    logic [ROB_AW-1:0]    restore_tail;
    logic [CPW-1:0]       restore_cp_id;
    logic                 redirect_valid;
    logic [`PC_SIZE-1:0]  redirect_pc;
    logic [CPW:0]         outstanding;

    int checkCount = 0;
    int passCount  = 0;

    branch_recovery_ctrl #(.CP_COUNT(CP_COUNT)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .alloc_req          (alloc_req),
        .alloc_rob_addr     (alloc_rob_addr),
        .alloc_grant        (alloc_grant),
        .alloc_cp_id        (alloc_cp_id),
        .dispatch_stall     (dispatch_stall),
        .resolve_valid      (resolve_valid),
        .resolve_cp_id      (resolve_cp_id),
        .resolve_mispredict (resolve_mispredict),
        .resolve_target     (resolve_target),
        .resolve_ready      (resolve_ready),
        .restore            (restore),
        .restore_tail       (restore_tail),
        .restore_cp_id      (restore_cp_id),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .outstanding        (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic stepClock();
        @(posedge clk);
        #2;
    endtask

    // Drive all stimulus inputs, then let combinational outputs settle
    task automatic applyStimulus(input logic req, input logic [ROB_AW-1:0] addr,
                                 input logic rv, input logic [CPW-1:0] rcp,
                                 input logic rmis, input logic [`PC_SIZE-1:0] rtgt);
        alloc_req          = req;
        alloc_rob_addr     = addr;
        resolve_valid      = rv;
        resolve_cp_id      = rcp;
        resolve_mispredict = rmis;
        resolve_target     = rtgt;
        #1;
    endtask

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic doReset();
        n_rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepClock();
        stepClock();
        n_rst = 1'b1;
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset state
        doReset();
        checkOutput("rst_grant",    32'(alloc_grant),    0);
        checkOutput("rst_outst",    32'(outstanding),    0);
        checkOutput("rst_ready",    32'(resolve_ready),  1);
        checkOutput("rst_stall",    32'(dispatch_stall), 0);
        checkOutput("rst_restore",  32'(restore),        0);
        checkOutput("rst_redirect", 32'(redirect_valid), 0);
        checkOutput("rst_cpid",     32'(alloc_cp_id),    0);
        checkOutput("rst_rpc",      32'(redirect_pc),    0);

        // Fill all four slots
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("fill0_grant", 32'(alloc_grant), 1);
        checkOutput("fill0_cpid",  32'(alloc_cp_id), 0);
        stepClock();
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("fill1_cpid",  32'(alloc_cp_id), 1);
        checkOutput("fill1_outst", 32'(outstanding), 1);
        stepClock();
        applyStimulus(1, 9, 0, 0, 0, 0);
        checkOutput("fill2_cpid",  32'(alloc_cp_id), 2);
        stepClock();
        applyStimulus(1, 12, 0, 0, 0, 0);
        checkOutput("fill3_cpid",  32'(alloc_cp_id), 3);
        checkOutput("fill3_grant", 32'(alloc_grant), 1);
        stepClock();
        applyStimulus(1, 7, 0, 0, 0, 0);
        checkOutput("full_outst", 32'(outstanding),    4);
        checkOutput("full_stall", 32'(dispatch_stall), 1);
        checkOutput("full_grant", 32'(alloc_grant),    0);

        // Out-of-order correct resolutions, in-order retirement
        applyStimulus(0, 0, 1, 1, 0, 32'h10);
        checkOutput("res1_ready", 32'(resolve_ready), 1);
        stepClock();
        applyStimulus(0, 0, 1, 0, 0, 32'h20);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ret_outst4", 32'(outstanding), 4);
        stepClock();
        checkOutput("ret_outst3", 32'(outstanding),    3);
        checkOutput("ret_stall",  32'(dispatch_stall), 0);
        stepClock();
        checkOutput("ret_outst2", 32'(outstanding), 2);

        // Mispredict on cp1 with all four slots live
        doReset();
        applyStimulus(1, 3, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 5, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 9, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 12, 0, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 1, 1, 1, 32'h40);
        checkOutput("mp_ready_n", 32'(resolve_ready), 1);
        checkOutput("mp_restore_n", 32'(restore), 0);
        stepClock();
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("fl_restore",  32'(restore),        1);
        checkOutput("fl_rtail",    32'(restore_tail),   6);
        checkOutput("fl_rcpid",    32'(restore_cp_id),  1);
        checkOutput("fl_ready",    32'(resolve_ready),  0);
        checkOutput("fl_grant",    32'(alloc_grant),    0);
        checkOutput("fl_redirect", 32'(redirect_valid), 0);
        stepClock();
        checkOutput("rd_valid",   32'(redirect_valid), 1);
        checkOutput("rd_pc",      32'(redirect_pc),    32'h40);
        checkOutput("rd_restore", 32'(restore),        0);
        checkOutput("rd_outst",   32'(outstanding),    1);
        checkOutput("rd_grant",   32'(alloc_grant),    0);
        checkOutput("rd_ready",   32'(resolve_ready),  0);
        stepClock();
        applyStimulus(1, 8, 0, 0, 0, 0);
        checkOutput("post_grant",    32'(alloc_grant),    1);
        checkOutput("post_cpid",     32'(alloc_cp_id),    1);
        checkOutput("post_redirect", 32'(redirect_valid), 0);
        stepClock();

        // Mispredict cp1 (rob 8) with a same-cycle allocation into cp2
        applyStimulus(1, 10, 1, 1, 1, 32'h80);
        checkOutput("sim_grant", 32'(alloc_grant), 1);
        checkOutput("sim_cpid",  32'(alloc_cp_id), 2);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sim_outst_fl", 32'(outstanding),   3);
        checkOutput("sim_rtail",    32'(restore_tail),  9);
        checkOutput("sim_rcpid",    32'(restore_cp_id), 1);
        stepClock();
        checkOutput("sim_rpc",   32'(redirect_pc), 32'h80);
        checkOutput("sim_outst", 32'(outstanding), 1);
        stepClock();
        applyStimulus(1, 11, 0, 0, 0, 0);
        checkOutput("sim_recpid", 32'(alloc_cp_id), 1);
        checkOutput("sim_regrant", 32'(alloc_grant), 1);

        // Mispredict at the last ROB entry wraps restore_tail to zero
        doReset();
        applyStimulus(1, 4'(`ROB_SIZE - 1), 0, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1, 32'h100);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_rtail",  32'(restore_tail),  0);
        checkOutput("wrap_rcpid",  32'(restore_cp_id), 0);
        stepClock();
        checkOutput("wrap_rpc",   32'(redirect_pc), 32'h100);
        checkOutput("wrap_outst", 32'(outstanding), 0);
        stepClock();

        // Twelve back-to-back alloc/resolve cycles wrap head and tail
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 4'(i), (i > 0), 2'((i + 3) % 4), 0, 32'(i));
            checkOutput("loop_grant", 32'(alloc_grant), 1);
            checkOutput("loop_cpid",  32'(alloc_cp_id), 32'(i % 4));
            checkOutput("loop_outst", 32'(outstanding), 32'((i < 2) ? i : 2));
            stepClock();
        end
        applyStimulus(0, 0, 1, 3, 0, 32'hC);
        checkOutput("drain_outst2", 32'(outstanding), 2);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepClock();
        checkOutput("drain_outst0", 32'(outstanding), 0);
        checkOutput("drain_cpid",   32'(alloc_cp_id), 0);

        // Reset asserted during FLUSH abandons the recovery
        doReset();
        applyStimulus(1, 2, 0, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1, 32'h200);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rf_restore", 32'(restore), 1);
        n_rst = 1'b0;
        stepClock();
        checkOutput("rf_restore0",  32'(restore),        0);
        checkOutput("rf_redirect0", 32'(redirect_valid), 0);
        checkOutput("rf_outst0",    32'(outstanding),    0);
        checkOutput("rf_ready",     32'(resolve_ready),  1);
        n_rst = 1'b1;
        stepClock();
        checkOutput("rf_redirect1", 32'(redirect_valid), 0);
        checkOutput("rf_stall",     32'(dispatch_stall), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
